// File: rtl/life_grid_engine_pkg.sv
// Shared types and Life-rule helpers for the grid engine and its row evaluator.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROW    = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] BIRTH      = 4'd3;
  localparam logic [3:0] SURVIVE_LO = 4'd2;
  localparam logic [3:0] SURVIVE_HI = 4'd3;

  // Flat bit index of cell (r,c) in a grid whose rows are w cells wide.
  function automatic int cell_idx(input int r, input int c, input int w);
    return r * w + c;
  endfunction

  function automatic logic rule_next(input logic alive, input logic [3:0] n);
    if (alive) return (n >= SURVIVE_LO) && (n <= SURVIVE_HI);
    else       return (n == BIRTH);
  endfunction

endpackage

// File: rtl/life_grid_engine_if.sv
// Control/status bundle between the surrounding logic (master) and the engine (slave).
// Handshake: load/start are level inputs sampled only while the engine is in IDLE;
// done is a single-cycle pulse and the result signals are valid from that cycle on.
interface life_grid_engine_if #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int CW     = 16
);
  import life_pkg::*;

  logic                    load;
  logic [WIDTH*HEIGHT-1:0] grid_in;
  logic                    start;
  logic [CW-1:0]           gen_req;
  logic                    torus;
  logic [WIDTH*HEIGHT-1:0] grid_out;
  logic                    busy;
  logic                    done;
  logic [CW-1:0]           gens_done;
  logic                    stable;
  logic                    extinct;
  state_t                  state;

  modport master (
    output load, grid_in, start, gen_req, torus,
    input  grid_out, busy, done, gens_done, stable, extinct, state
  );

  modport slave (
    input  load, grid_in, start, gen_req, torus,
    output grid_out, busy, done, gens_done, stable, extinct, state
  );
endinterface

// File: rtl/life_grid_engine_row_eval.sv
// Combinational next-state of one grid row from the rows above, at and below it.
module life_row_eval
  import life_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] up,
  input  logic [WIDTH-1:0] mid,
  input  logic [WIDTH-1:0] dn,
  input  logic             torus,
  output logic [WIDTH-1:0] next_row
);

  for (genvar c = 0; c < WIDTH; c++) begin : g_cell
    localparam int L = (c == 0) ? WIDTH - 1 : c - 1;
    localparam int R = (c == WIDTH - 1) ? 0 : c + 1;

    // Edge columns only see their wrapped neighbour when the torus is enabled.
    logic       l_ok;
    logic       r_ok;
    logic [3:0] n;

    assign l_ok = (c == 0) ? torus : 1'b1;
    assign r_ok = (c == WIDTH - 1) ? torus : 1'b1;

    assign n = 4'(up[c]) + 4'(dn[c])
             + 4'(up[L] & l_ok) + 4'(mid[L] & l_ok) + 4'(dn[L] & l_ok)
             + 4'(up[R] & r_ok) + 4'(mid[R] & r_ok) + 4'(dn[R] & r_ok);

    assign next_row[c] = rule_next(mid[c], n);
  end

endmodule

// File: rtl/life_grid_engine.sv
// Game-of-Life engine: evolves the committed grid one row per cycle, committing whole generations.
module life_grid_engine
  import life_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int HEIGHT         = 8,
  parameter int CW             = 16,
  parameter bit STOP_ON_STABLE = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  life_grid_engine_if.slave  bus
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int RW = $clog2(HEIGHT);
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

  state_t        state;
  logic [N-1:0]  grid_q;
  logic [N-1:0]  nxt_q;
  logic [RW-1:0] row;
  logic [CW-1:0] gen_req_q;
  logic [CW-1:0] gens_done;
  logic [CW-1:0] gens_inc;
  logic          torus_q;
  logic          busy;
  logic          done;
  logic          stable;
  logic          extinct;
  logic          same;

  logic [RW-1:0]    row_up;
  logic [RW-1:0]    row_dn;
  logic [WIDTH-1:0] up_row;
  logic [WIDTH-1:0] mid_row;
  logic [WIDTH-1:0] dn_row;
  logic [WIDTH-1:0] new_row;

  // Row neighbours are always read from the committed grid, never from the buffer being built.
  always_comb begin
    row_up  = (row == '0) ? LAST_ROW : row - 1'b1;
    row_dn  = (row == LAST_ROW) ? '0 : row + 1'b1;
    mid_row = grid_q[cell_idx(int'(row), 0, WIDTH) +: WIDTH];
    up_row  = grid_q[cell_idx(int'(row_up), 0, WIDTH) +: WIDTH];
    dn_row  = grid_q[cell_idx(int'(row_dn), 0, WIDTH) +: WIDTH];
    if (!torus_q && row == '0)      up_row = '0;
    if (!torus_q && row == LAST_ROW) dn_row = '0;
  end

  life_row_eval #(.WIDTH(WIDTH)) u_row_eval (
    .up       (up_row),
    .mid      (mid_row),
    .dn       (dn_row),
    .torus    (torus_q),
    .next_row (new_row)
  );

  assign gens_inc = gens_done + 1'b1;
  assign same     = (nxt_q == grid_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      grid_q    <= '0;
      nxt_q     <= '0;
      row       <= '0;
      gen_req_q <= '0;
      gens_done <= '0;
      torus_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stable    <= 1'b0;
      extinct   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            grid_q  <= bus.grid_in;
            stable  <= 1'b0;
            extinct <= 1'b0;
          end else if (bus.start) begin
            gen_req_q <= bus.gen_req;
            torus_q   <= bus.torus;
            gens_done <= '0;
            row       <= '0;
            if (bus.gen_req == '0) begin
              state <= DONE;
            end else begin
              state <= ROW;
              busy  <= 1'b1;
            end
          end
        end
        ROW: begin
          nxt_q[cell_idx(int'(row), 0, WIDTH) +: WIDTH] <= new_row;
          if (row == LAST_ROW) begin
            row   <= '0;
            state <= COMMIT;
          end else begin
            row <= row + 1'b1;
          end
        end
        COMMIT: begin
          grid_q    <= nxt_q;
          gens_done <= gens_inc;
          stable    <= same;
          extinct   <= (nxt_q == '0);
          if (gens_inc == gen_req_q || (STOP_ON_STABLE && same)) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            state <= ROW;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grid_out  = grid_q;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.gens_done = gens_done;
  assign bus.stable    = stable;
  assign bus.extinct   = extinct;
  assign bus.state     = state;

endmodule

// File: doc/life_grid_engine.md
Name: life_grid_engine

Overview:
- Parametrised Game-of-Life evolution engine; successor to the fixed 8x8 single-step `data` evolver.
- Holds a WIDTH x HEIGHT grid and evolves it one row per cycle, for a requested number of generations.
- Supports optional toroidal wrap and early stop on a still-life.
- Reports completion, generations executed, and stable/extinct status to the surrounding control/display logic.

Parameters:
- WIDTH, 8, cells per row (>=3)
- HEIGHT, 8, rows (>=3)
- CW, 16, width of the generation request and generation counter
- STOP_ON_STABLE, 1, when 1 the run terminates early once a generation leaves the grid unchanged

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- load  in  1  in IDLE: copy grid_in into the working grid
- grid_in  in  WIDTH*HEIGHT  initial grid; cell (r,c) = bit r*WIDTH+c; row 0 occupies bits [WIDTH-1:0]
- start  in  1  in IDLE: begin a run of gen_req generations
- gen_req  in  CW  number of generations to run; sampled on start
- torus  in  1  1 = edges wrap, 0 = out-of-grid cells read as dead; sampled on start
- grid_out  out  WIDTH*HEIGHT  committed grid; same bit mapping as grid_in
- busy  out  1  high in ROW and COMMIT
- done  out  1  one-cycle pulse when a run ends
- gens_done  out  CW  generations committed in the current/last run
- stable  out  1  last committed generation equalled its predecessor
- extinct  out  1  last committed grid is all zero

Behaviour:
- Reset (reset==0 at a clk edge) takes priority over everything, including mid-run. Results:
  - state = IDLE
  - grid_out = 0, next buffer = 0, row index = 0
  - gens_done = 0; busy, done, stable, extinct = 0
- Life rule: a live cell survives with 2 or 3 live neighbours; a dead cell is born with exactly 3; every other cell is dead.
  - Neighbour count is 4 bits, range 0..8.
- Wrap: with torus=1, row indices are taken mod HEIGHT and column indices mod WIDTH. With torus=0, neighbours outside the grid count as 0.
- States:
  - IDLE:
    - load=1: grid_out <= grid_in; stable and extinct cleared.
    - else start=1: latch gen_req and torus, gens_done <= 0.
      - latched gen_req==0: go to DONE.
      - else go to ROW with row=0.
    - load and start in the same cycle: load wins and start is ignored.
  - ROW: each cycle compute next row r from grid_out (rows r-1, r, r+1) into the next buffer; row increments. Leaving rule:
    - row==HEIGHT-1: go to COMMIT.
    - otherwise stay in ROW.
  - COMMIT (one cycle):
    - grid_out <= next buffer; gens_done += 1
    - stable <= (next==grid_out); extinct <= (next==0)
    - Go to DONE if gens_done+1==latched gen_req, or if STOP_ON_STABLE and the grid was unchanged.
    - Otherwise go to ROW with row=0.
  - DONE: done=1 for exactly this cycle, then IDLE.
- grid_out never changes during ROW; it updates only in COMMIT or on load.
- Latency:
  - Each generation costs HEIGHT+1 cycles.
  - A full run of N generations takes N*(HEIGHT+1) cycles from the start edge to DONE entry; done is asserted on the following cycle.
  - gen_req==0: done is asserted 1 cycle after start; grid and flags are unchanged.
- While busy, load and start are ignored; grid_in changes have no effect.
- gens_done saturates naturally at gen_req, because gen_req bounds the run.

Decomposition:
- Package life_pkg holds:
  - state enum (IDLE, ROW, COMMIT, DONE)
  - function cell_idx(r,c)
  - constants for the rule (BIRTH=3, SURVIVE_LO=2, SURVIVE_HI=3)
- Sub-module life_row_eval (combinational): inputs are the three neighbouring rows (WIDTH bits each) and torus; output is the next row. Engine instantiates it once and time-multiplexes it across rows.

Test Plan:
- Blinker, 8x8, torus=0:
  - Stimulus: load 64'h0000_0000_1C00_0000, start gen_req=1.
  - Response: done is asserted 10 cycles after the start edge; grid_out=64'h0000_0008_0808_0000; gens_done=1; stable=0; extinct=0.
- Still life, STOP_ON_STABLE=1:
  - Stimulus: load 64'h0000_0000_0000_0303, gen_req=5.
  - Response: run stops after 1 generation; gens_done=1; stable=1; grid_out=64'h0303.
- Extinction:
  - Stimulus: load 64'h1, gen_req=4.
  - Response: after gen 1 grid_out=0 and extinct=1; gen 2 sets stable=1 and stops the run; gens_done=2.
- Edge wrap:
  - Stimulus: load 64'h83, gen_req=1.
  - Response with torus=1: grid_out=64'h0100_0000_0000_0101.
  - Response with torus=0: grid_out=0 and extinct=1.
- Control corners:
  - load+start in the same cycle: only the load takes effect, busy stays 0.
  - load/start pulsed mid-run: ignored, result unchanged.
  - gen_req=0: done 1 cycle after start, gens_done=0.
  - reset=0 asserted mid-ROW: next cycle IDLE, grid_out=0, busy=0, done=0.
- Parametric (WIDTH=16, HEIGHT=4, torus=0):
  - Stimulus: load a horizontal blinker at row 1, cols 5..7 (bits 21..23), gen_req=2.
  - Response: back to the original pattern; gens_done=2; done asserted 11 cycles after start; stable=0.
